// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between a read-only fetch requester and a
// read/write data requester; one transaction in flight, data has priority.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [2:0]  I_SIZE       = 3'b010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [2:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        m_wr_q, m_wr_d;
    logic [2:0]  m_size_q, m_size_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [2:0]  starve_q, starve_d;
    logic        i_grant, d_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_size_q  <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            m_wr_q    <= m_wr_d;
            m_size_q  <= m_size_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            starve_q  <= starve_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        m_wr_d    = m_wr_q;
        m_size_d  = m_size_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        starve_d  = starve_q;
        i_grant   = 1'b0;
        d_grant   = 1'b0;
        case (state_q)
            IDLE: begin
                // Fetch wins a contested cycle only once the counter hits the limit
                if (d_req && !(i_req && starve_q == LIMIT)) begin
                    d_grant   = 1'b1;
                    owner_d   = 1'b1;
                    m_wr_d    = d_wr;
                    m_size_d  = d_size;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    state_d   = ADDR;
                    if (!i_req)
                        starve_d = '0;
                    else if (starve_q != LIMIT)
                        starve_d = starve_q + 3'd1;
                end else if (i_req) begin
                    i_grant   = 1'b1;
                    owner_d   = 1'b0;
                    m_wr_d    = 1'b0;
                    m_size_d  = I_SIZE;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                    starve_d  = '0;
                    state_d   = ADDR;
                end
            end
            ADDR:    if (m_addr_ok) state_d = DATA;
            DATA:    if (m_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign i_addr_ok = i_grant & rst_n;
    assign d_addr_ok = d_grant & rst_n;
    assign i_data_ok = rst_n & (state_q == DATA) & m_data_ok & ~owner_q;
    assign d_data_ok = rst_n & (state_q == DATA) & m_data_ok & owner_q;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;
    assign m_req     = (state_q == ADDR);
    assign m_wr      = m_wr_q;
    assign m_size    = m_size_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written
// sequences for starvation, memory stall and reset mid-transaction.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_wr, m_addr_ok, m_data_ok;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [2:0]  d_size;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        m_req, m_wr, busy, owner;
    logic [2:0]  m_size;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4), .I_SIZE(3'b010)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata), .busy(busy), .owner(owner)
    );

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq, dwr;
        logic [2:0]  dsize;
        logic [31:0] daddr, dwdata;
        logic        maok, mdok;
        logic [31:0] mrdata;
        logic        iaok, daok, idok, ddok, mreq, mwr;
        logic [2:0]  msize;
        logic [31:0] maddr, mwdata;
        logic        busy, owner;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Row layout: inputs | ireq iaddr dreq dwr dsize daddr dwdata maok mdok mrdata
        //             expect | iaok daok idok ddok mreq mwr msize maddr mwdata busy owner
        vecs[0]  = '{1, 32'h1C000000, 0, 0, 3'd0, 32'h0,   32'h0,    0, 0, 32'h0,
                     1, 0, 0, 0, 0, 0, 3'd0, 32'h0,        32'h0,    0, 0};
        vecs[1]  = '{0, 32'h0,        0, 0, 3'd0, 32'h0,   32'h0,    1, 0, 32'h0,
                     0, 0, 0, 0, 1, 0, 3'd2, 32'h1C000000, 32'h0,    1, 0};
        vecs[2]  = '{0, 32'h0,        0, 0, 3'd0, 32'h0,   32'h0,    0, 1, 32'h02800C0C,
                     0, 0, 1, 0, 0, 0, 3'd2, 32'h1C000000, 32'h0,    1, 0};
        vecs[3]  = '{0, 32'h0,        0, 0, 3'd0, 32'h0,   32'h0,    0, 0, 32'h0,
                     0, 0, 0, 0, 0, 0, 3'd2, 32'h1C000000, 32'h0,    0, 0};
        vecs[4]  = '{0, 32'h0,        1, 1, 3'd1, 32'h8,   32'hABCD, 0, 0, 32'h0,
                     0, 1, 0, 0, 0, 0, 3'd2, 32'h1C000000, 32'h0,    0, 0};
        vecs[5]  = '{0, 32'h0,        0, 0, 3'd0, 32'h0,   32'h0,    1, 0, 32'h0,
                     0, 0, 0, 0, 1, 1, 3'd1, 32'h8,        32'hABCD, 1, 1};
        vecs[6]  = '{0, 32'h0,        0, 0, 3'd0, 32'h0,   32'h0,    0, 1, 32'hDEADBEEF,
                     0, 0, 0, 1, 0, 1, 3'd1, 32'h8,        32'hABCD, 1, 1};
        vecs[7]  = '{0, 32'h0,        0, 0, 3'd0, 32'h0,   32'h0,    0, 0, 32'h0,
                     0, 0, 0, 0, 0, 1, 3'd1, 32'h8,        32'hABCD, 0, 1};
        vecs[8]  = '{1, 32'h100,      1, 0, 3'd2, 32'h200, 32'h0,    0, 0, 32'h0,
                     0, 1, 0, 0, 0, 1, 3'd1, 32'h8,        32'hABCD, 0, 1};
        vecs[9]  = '{1, 32'h100,      0, 0, 3'd0, 32'h0,   32'h0,    1, 0, 32'h0,
                     0, 0, 0, 0, 1, 0, 3'd2, 32'h200,      32'h0,    1, 1};
        vecs[10] = '{1, 32'h100,      0, 0, 3'd0, 32'h0,   32'h0,    0, 1, 32'h11112222,
                     0, 0, 0, 1, 0, 0, 3'd2, 32'h200,      32'h0,    1, 1};
        vecs[11] = '{1, 32'h100,      0, 0, 3'd0, 32'h0,   32'h0,    0, 0, 32'h0,
                     1, 0, 0, 0, 0, 0, 3'd2, 32'h200,      32'h0,    0, 1};
        vecs[12] = '{0, 32'h0,        0, 0, 3'd0, 32'h0,   32'h0,    0, 1, 32'h55556666,
                     0, 0, 0, 0, 1, 0, 3'd2, 32'h100,      32'h0,    1, 0};
        vecs[13] = '{0, 32'h0,        0, 0, 3'd0, 32'h0,   32'h0,    1, 0, 32'h0,
                     0, 0, 0, 0, 1, 0, 3'd2, 32'h100,      32'h0,    1, 0};
        vecs[14] = '{0, 32'h0,        0, 0, 3'd0, 32'h0,   32'h0,    0, 1, 32'h33334444,
                     0, 0, 1, 0, 0, 0, 3'd2, 32'h100,      32'h0,    1, 0};
        vecs[15] = '{0, 32'h0,        0, 0, 3'd0, 32'h0,   32'h0,    0, 0, 32'h0,
                     0, 0, 0, 0, 0, 0, 3'd2, 32'h100,      32'h0,    0, 0};
    end

    initial begin
        int grants;
        int cyc;
        string seq;
        string exp_seq;

        rst_n = 1'b0;
        {i_req, d_req, d_wr, m_addr_ok, m_data_ok} = '0;
        {i_addr, d_addr, d_wdata, m_rdata} = '0;
        d_size = '0;
        #1;
        next_cycle();
        @(negedge clk);
        chk("rst_m_req", m_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_size", m_size, 0);
        chk("rst_oks", {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 0);
        rst_n = 1'b1;
        next_cycle();

        for (int v = 0; v < 16; v++) begin
            i_req = vecs[v].ireq;   i_addr  = vecs[v].iaddr;
            d_req = vecs[v].dreq;   d_wr    = vecs[v].dwr;
            d_size = vecs[v].dsize; d_addr  = vecs[v].daddr;
            d_wdata = vecs[v].dwdata;
            m_addr_ok = vecs[v].maok; m_data_ok = vecs[v].mdok;
            m_rdata = vecs[v].mrdata;
            @(negedge clk);
            chk($sformatf("v%0d_i_addr_ok", v), i_addr_ok, vecs[v].iaok);
            chk($sformatf("v%0d_d_addr_ok", v), d_addr_ok, vecs[v].daok);
            chk($sformatf("v%0d_i_data_ok", v), i_data_ok, vecs[v].idok);
            chk($sformatf("v%0d_d_data_ok", v), d_data_ok, vecs[v].ddok);
            chk($sformatf("v%0d_m_req", v), m_req, vecs[v].mreq);
            chk($sformatf("v%0d_m_wr", v), m_wr, vecs[v].mwr);
            chk($sformatf("v%0d_m_size", v), m_size, vecs[v].msize);
            chk($sformatf("v%0d_m_addr", v), m_addr, vecs[v].maddr);
            chk($sformatf("v%0d_m_wdata", v), m_wdata, vecs[v].mwdata);
            chk($sformatf("v%0d_busy", v), busy, vecs[v].busy);
            chk($sformatf("v%0d_owner", v), owner, vecs[v].owner);
            chk($sformatf("v%0d_i_rdata", v), i_rdata, vecs[v].mrdata);
            chk($sformatf("v%0d_d_rdata", v), d_rdata, vecs[v].mrdata);
            next_cycle();
        end

        // Starvation: both requesters held, zero-wait memory
        i_req = 1; i_addr = 32'h1000; d_req = 1; d_wr = 0; d_size = 3'd2;
        d_addr = 32'h2000; d_wdata = 0; m_addr_ok = 1; m_data_ok = 1;
        grants = 0; seq = ""; exp_seq = "DDDDFDDDDF";
        for (cyc = 0; cyc < 60 && grants < 10; cyc++) begin
            @(negedge clk);
            if (i_addr_ok && d_addr_ok) seq = {seq, "X"};
            else if (d_addr_ok) seq = {seq, "D"};
            else if (i_addr_ok) seq = {seq, "F"};
            if (i_addr_ok || d_addr_ok) grants++;
            if (grants < 10) next_cycle();
        end
        tests++;
        if (seq != exp_seq) begin
            fails++;
            $display("FAIL starve_seq: got %s expected %s", seq, exp_seq);
        end
        next_cycle();
        i_req = 0; d_req = 0;
        for (cyc = 0; cyc < 10 && busy; cyc++) next_cycle();
        chk("starve_drain_busy", busy, 0);
        m_addr_ok = 0; m_data_ok = 0;

        // Memory stall on a data write with fetch waiting
        d_req = 1; d_wr = 1; d_size = 3'd2; d_addr = 32'h40; d_wdata = 32'h5A5A;
        i_req = 1; i_addr = 32'h300;
        @(negedge clk);
        chk("stall_d_addr_ok", d_addr_ok, 1);
        chk("stall_i_addr_ok0", i_addr_ok, 0);
        next_cycle();
        d_req = 0; d_wdata = 32'hFFFF; d_addr = 32'hFF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_m_req", k), m_req, 1);
            chk($sformatf("stall%0d_m_addr", k), m_addr, 32'h40);
            chk($sformatf("stall%0d_m_wdata", k), m_wdata, 32'h5A5A);
            chk($sformatf("stall%0d_i_addr_ok", k), i_addr_ok, 0);
            chk($sformatf("stall%0d_busy", k), busy, 1);
            next_cycle();
        end
        m_addr_ok = 1;
        @(negedge clk);
        chk("stall_ack_m_req", m_req, 1);
        next_cycle();
        m_addr_ok = 0; m_data_ok = 1;
        @(negedge clk);
        chk("stall_d_data_ok", d_data_ok, 1);
        chk("stall_i_data_ok", i_data_ok, 0);
        next_cycle();
        m_data_ok = 0;
        @(negedge clk);
        chk("stall_fetch_after", i_addr_ok, 1);
        next_cycle();
        i_req = 0; m_addr_ok = 1;
        next_cycle();
        m_addr_ok = 0; m_data_ok = 1;
        next_cycle();
        m_data_ok = 0;

        // Reset while in DATA
        d_req = 1; d_wr = 0; d_addr = 32'h500;
        @(negedge clk);
        chk("rstm_d_addr_ok", d_addr_ok, 1);
        next_cycle();
        d_req = 0; m_addr_ok = 1;
        next_cycle();
        m_addr_ok = 0;
        @(negedge clk);
        chk("rstm_pre_busy", busy, 1);
        chk("rstm_pre_owner", owner, 1);
        #1;
        rst_n = 0; m_data_ok = 1;
        #1;
        chk("rstm_m_req", m_req, 0);
        chk("rstm_busy", busy, 0);
        chk("rstm_owner", owner, 0);
        chk("rstm_d_data_ok", d_data_ok, 0);
        next_cycle();
        rst_n = 1;
        @(negedge clk);
        chk("rstm_rel_d_data_ok", d_data_ok, 0);
        chk("rstm_rel_i_data_ok", i_data_ok, 0);
        chk("rstm_rel_busy", busy, 0);
        next_cycle();
        m_data_ok = 0; d_req = 1; d_addr = 32'h600;
        @(negedge clk);
        chk("rstm_new_d_addr_ok", d_addr_ok, 1);
        next_cycle();
        d_req = 0; m_addr_ok = 1;
        @(negedge clk);
        chk("rstm_new_m_req", m_req, 1);
        chk("rstm_new_m_addr", m_addr, 32'h600);
        next_cycle();
        m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rstm_new_d_data_ok", d_data_ok, 1);
        chk("rstm_new_d_rdata", d_rdata, 32'hCAFEF00D);
        next_cycle();
        m_data_ok = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
